// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parameterised synchronous FIFO.
package fifo_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_AF_MARGIN = 2;   // almost_full threshold sits this far below DEPTH
    localparam int DEF_AE_THRESH = 2;

    // Pointer width: index bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    // Status after reset or flush: empty, nothing pending.
    localparam fifo_status_t STATUS_RST = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1,
        overflow:     1'b0,
        underflow:    1'b0
    };

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one synchronous write port, one
// asynchronous read port. Storage is intentionally not reset.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port: store the word at the write index on an accepted write.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_param.sv
// Parameterised synchronous FIFO with occupancy count, programmable
// almost-full/almost-empty, overflow/underflow pulses, synchronous flush and
// selectable registered or first-word-fall-through read.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - DEF_AF_MARGIN,
    parameter int AE_THRESH = DEF_AE_THRESH,
    parameter int FWFT      = 0
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       read_en,
    output logic [DATA_W-1:0]          data_out,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    localparam logic [PW-1:0] ONE  = PW'(1);
    localparam logic [PW-1:0] AF_C = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_C = PW'(AE_THRESH);

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     count_q,  count_d;
    fifo_status_t      status_q, status_d;
    logic [DATA_W-1:0] dout_q,   dout_d;

    logic              rd_acc, wr_acc, mem_we;
    logic [DATA_W-1:0] rdata;

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk    (clk),
        .we     (mem_we),
        .waddr  (wr_ptr_q[AW-1:0]),
        .wdata  (data_in),
        .raddr  (rd_ptr_q[AW-1:0]),
        .rdata  (rdata)
    );

    // A write into a full FIFO is only taken when a read frees a slot that cycle.
    assign rd_acc = read_en && !status_q.empty;
    assign wr_acc = wr_en && (!status_q.full || rd_acc);
    assign mem_we = wr_acc && !clr;

    // Next-state: pointers, occupancy, flags and registered read data; flush wins.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        status_d = status_q;
        dout_d   = dout_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            status_d = STATUS_RST;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
            if (rd_acc) rd_ptr_d = rd_ptr_q + ONE;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + ONE;
                2'b01:   count_d = count_q - ONE;
                default: count_d = count_q;
            endcase
            status_d.empty        = (wr_ptr_d == rd_ptr_d);
            status_d.full         = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) &&
                                    (wr_ptr_d[AW] != rd_ptr_d[AW]);
            status_d.almost_full  = (count_d >= AF_C);
            status_d.almost_empty = (count_d <= AE_C);
            status_d.overflow     = wr_en && !wr_acc;
            status_d.underflow    = read_en && status_q.empty;
            // Async read sees the head before any same-edge write lands.
            if (FWFT == 0 && rd_acc) dout_d = rdata;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            status_q <= STATUS_RST;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            status_q <= status_d;
            dout_q   <= dout_d;
        end
    end

    // FWFT shows the head straight from storage; zero while empty keeps reset clean.
    assign data_out     = (FWFT != 0) ? (status_q.empty ? '0 : rdata) : dout_q;
    assign empty        = status_q.empty;
    assign full         = status_q.full;
    assign almost_full  = status_q.almost_full;
    assign almost_empty = status_q.almost_empty;
    assign overflow     = status_q.overflow;
    assign underflow    = status_q.underflow;
    assign count        = count_q;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: a standard-mode and an FWFT instance share
// stimulus; standard-mode read data is checked through a scoreboard queue.
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       clr = 1'b0;
    logic       wr_en = 1'b0;
    logic       read_en = 1'b0;
    logic [7:0] data_in = '0;

    logic [7:0] s_data_out, f_data_out;
    logic       s_empty, s_full, s_af, s_ae, s_ovf, s_unf;
    logic       f_empty, f_full, f_af, f_ae, f_ovf, f_unf;
    logic [4:0] s_count, f_count;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic       rd_expect = 1'b0;
    logic       pend = 1'b0;

    fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u_std (
        .clk(clk), .rstN(rstN), .clr(clr), .wr_en(wr_en), .data_in(data_in),
        .read_en(read_en), .data_out(s_data_out), .empty(s_empty), .full(s_full),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf)
    );

    fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) u_fwft (
        .clk(clk), .rstN(rstN), .clr(clr), .wr_en(wr_en), .data_in(data_in),
        .read_en(read_en), .data_out(f_data_out), .empty(f_empty), .full(f_full),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs at a negedge; returns at the next negedge.
    task automatic step(input logic w, input logic [7:0] d, input logic r,
                        input logic c, input logic racc);
        wr_en     = w;
        data_in   = d;
        read_en   = r;
        clr       = c;
        rd_expect = racc;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: a read expected to be accepted shows its data one edge later.
    always @(posedge clk) pend <= rd_expect;

    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (pend) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_underrun: got %0h expected no read data", s_data_out);
            end else begin
                e = exp_q.pop_front();
                if (s_data_out !== e) begin
                    failures++;
                    $display("FAIL sb_data: got %0h expected %0h", s_data_out, e);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        // Reset state
        chk("rst_empty", s_empty, 1);
        chk("rst_ae", s_ae, 1);
        chk("rst_full", s_full, 0);
        chk("rst_af", s_af, 0);
        chk("rst_count", s_count, 0);
        chk("rst_dout", s_data_out, 0);
        chk("rst_ovf", s_ovf, 0);
        chk("rst_unf", s_unf, 0);
        rstN = 1'b1;
        @(negedge clk);

        // Fill 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            chk("fill_count", s_count, i);
            if (i == 2)  chk("fill_ae2", s_ae, 1);
            if (i == 3)  chk("fill_ae3", s_ae, 0);
            if (i == 13) chk("fill_af13", s_af, 0);
            if (i == 14) begin
                chk("fill_af14", s_af, 1);
                chk("fill_full14", s_full, 0);
            end
        end
        chk("fill_full", s_full, 1);
        chk("fill_f_full", f_full, 1);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        chk("ovf_pulse", s_ovf, 1);
        chk("ovf_count", s_count, 16);
        idle();
        chk("ovf_clear", s_ovf, 0);

        // Full: simultaneous write 0xAA and read
        exp_q.push_back(8'h01);
        step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1);
        chk("rw_full_count", s_count, 16);
        chk("rw_full_ovf", s_ovf, 0);
        chk("rw_full_full", s_full, 1);

        // Drain: 0x02..0x10 then 0xAA
        for (int k = 1; k <= 16; k++) begin
            exp_q.push_back((k <= 15) ? 8'(k + 1) : 8'hAA);
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            chk("drain_count", s_count, 16 - k);
            if (k == 2)  chk("drain_af14", s_af, 1);
            if (k == 3)  chk("drain_af13", s_af, 0);
            if (k == 13) chk("drain_ae3", s_ae, 0);
            if (k == 14) chk("drain_ae2", s_ae, 1);
        end
        chk("drain_empty", s_empty, 1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("unf_pulse", s_unf, 1);
        chk("unf_dout_hold", s_data_out, 8'hAA);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("unf_repeat", s_unf, 1);
        idle();
        chk("unf_clear", s_unf, 0);

        // Empty: simultaneous write and read
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        chk("rw_empty_unf", s_unf, 1);
        chk("rw_empty_count", s_count, 1);
        chk("rw_empty_empty", s_empty, 0);
        chk("rw_empty_fwft", f_data_out, 8'h77);
        exp_q.push_back(8'h77);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("rw_empty_drain", s_empty, 1);

        // FWFT: word appears without read_en
        step(1'b1, 8'h5C, 1'b0, 1'b0, 1'b0);
        chk("fwft_dout", f_data_out, 8'h5C);
        chk("fwft_nonempty", f_empty, 0);
        chk("std_hold", s_data_out, 8'h77);
        exp_q.push_back(8'h5C);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("fwft_pop_empty", f_empty, 1);
        chk("fwft_pop_count", f_count, 0);

        // Steady state at count=8 with pointer wrap
        for (int i = 0; i < 8; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b0);
        chk("wrap_pre_count", s_count, 8);
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back((i < 8) ? 8'h80 + 8'(i) : 8'h90 + 8'(i - 8));
            step(1'b1, 8'h90 + 8'(i), 1'b1, 1'b0, 1'b1);
            chk("wrap_count", s_count, 8);
            chk("wrap_flags", {s_full, s_empty, s_af, s_ae}, 0);
        end

        // Flush with concurrent write
        step(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
        chk("clr_count", s_count, 0);
        chk("clr_empty", s_empty, 1);
        chk("clr_ae", s_ae, 1);
        chk("clr_ovf", s_ovf, 0);
        chk("clr_dout_hold", s_data_out, 8'h9B);
        chk("clr_f_count", f_count, 0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("clr_unf_suppr", s_unf, 0);
        idle();

        // Async reset mid-burst at count=5
        for (int i = 0; i < 5; i++) step(1'b1, 8'h41 + 8'(i), 1'b0, 1'b0, 1'b0);
        chk("mid_count", s_count, 5);
        wr_en = 1'b1;
        data_in = 8'h46;
        #2 rstN = 1'b0;
        #1;
        chk("arst_empty", s_empty, 1);
        chk("arst_count", s_count, 0);
        chk("arst_ae", s_ae, 1);
        chk("arst_af_full", {s_af, s_full}, 0);
        chk("arst_dout", s_data_out, 0);
        chk("arst_pulses", {s_ovf, s_unf}, 0);
        chk("arst_f_empty", f_empty, 1);
        wr_en = 1'b0;
        data_in = 8'h00;
        @(negedge clk);
        rstN = 1'b1;
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        chk("post_rst_count", s_count, 1);
        chk("post_rst_fwft", f_data_out, 8'h33);
        exp_q.push_back(8'h33);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("post_rst_empty", s_empty, 1);
        idle();
        chk("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous FIFO; next-generation replacement for the fixed-size fifo block.
- Generalised in data width and depth.
- Adds occupancy count, programmable almost-full/almost-empty flags, overflow/underflow error pulses and a synchronous flush.
- Selectable standard (registered read, 1-cycle latency) or first-word-fall-through (FWFT) read mode; sits between a producer and consumer in one clock domain.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=4
AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = standard read mode, 1 = first-word-fall-through

Ports:
clk  input  1  clock, all logic on rising edge
rstN  input  1  asynchronous active-low reset
clr  input  1  synchronous flush, empties FIFO
wr_en  input  1  write request
data_in  input  DATA_W  write data
read_en  input  1  read request
data_out  output  DATA_W  read data
empty  output  1  no entries
full  output  1  DEPTH entries
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: rejected write
underflow  output  1  one-cycle pulse: rejected read

Behaviour:
- Reset (rstN low, async), required output values:
  - Pointers = 0 and count = 0.
  - empty = 1, almost_empty = 1.
  - full = 0, almost_full = 0.
  - data_out = 0, overflow = 0, underflow = 0.
  - Memory contents are don't-care.
  - Reset mid-operation discards all data; the first post-reset read sees the first post-reset write.
- Pointers: wr_ptr/rd_ptr carry one extra wrap bit.
  - empty when pointers are equal.
  - full when index bits are equal and wrap bits differ.
  - Index wraps DEPTH-1 -> 0 with the wrap bit toggled.
- Read acceptance: rd_acc = read_en && !empty.
- Write acceptance: wr_acc = wr_en && (!full || rd_acc). When full, a write is accepted only alongside an accepted read.
- Count update: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither are accepted.
  - All flags and count are registered and reflect post-update state the cycle after the edge.
- Simultaneous read and write when empty:
  - Write accepted, read rejected, underflow pulses.
  - Standard mode: the new word is readable from the next cycle.
  - FWFT mode: the new word appears on data_out the next cycle.
- overflow = registered (wr_en && !wr_acc); underflow = registered (read_en && empty). Each is a 1-cycle pulse per offending cycle; consecutive offending cycles keep it high.
- Standard mode (FWFT=0):
  - On rd_acc, data_out updates at the next edge with the head word (1-cycle latency).
  - Otherwise data_out holds its last value.
- FWFT mode (FWFT=1):
  - data_out presents the head word combinationally from storage while !empty.
  - read_en acts as acknowledge/pop; data_out is undefined while empty.
- clr: synchronous, priority over wr_en/read_en in the same cycle.
  - Pointers and count return to 0; flags go to their reset values.
  - overflow/underflow pulses are suppressed that cycle; data_out unchanged.
- Rejected operations never move pointers or corrupt stored data.

Decomposition:
- Package fifo_pkg:
  - Function computing pointer width ($clog2(DEPTH)+1).
  - typedef fifo_status_t packing {full, empty, almost_full, almost_empty, overflow, underflow}, for the interface and coverage.
  - Localparam default thresholds.
- Sub-module fifo_mem: simple dual-port register array.
  - One write port (we, waddr, wdata).
  - One asynchronous read port (raddr, rdata).
  - No reset on storage.
- fifo_param contains the pointers, count, flag logic and read-mode mux.

Test Plan:
- Reset then 16 writes of 0x01..0x10 (DEPTH=16, AF=14, AE=2) -> almost_full rises after the 14th write, full after the 16th, count=16; 17th write -> overflow pulse 1 cycle, count stays 16.
- From full, 16 reads (FWFT=0) -> data_out 0x01..0x10 each one cycle after read_en; almost_empty at count=2; empty after the last read; next read -> underflow pulse.
- Full FIFO, wr_en and read_en same cycle with data_in=0xAA -> both accepted, count stays 16, no overflow; 0xAA emerges as the 16th subsequent read.
- FWFT=1, empty, write 0x5C -> data_out=0x5C one cycle later without read_en; read_en pops it, empty=1.
- 20 write/read cycles at count=8 -> pointers wrap past index 15, data order preserved, flags stable; then clr together with wr_en -> count=0, empty=1, write ignored, no overflow.
- rstN low mid-burst at count=5 -> immediately empty=1, count=0, outputs at reset values; write 0x33 after release -> first read returns 0x33.
